// File: rtl/intpol2_d4_out_fifo_pkg.sv
// intpol2_d4_out_fifo_pkg
// Shared defaults and the storage entry layout for the intpol2_D4 output FIFO.
//   DATAPATH_WIDTH_DEF : default sample width
//   DEPTH_LOG2_DEF     : default log2 of FIFO depth
//   AFULL_MARGIN_DEF   : entries of headroom kept when Afull_o asserts
//   entry_t            : {last, data} as held in storage
package intpol2_d4_out_fifo_pkg;
  localparam int DATAPATH_WIDTH_DEF = 32;
  localparam int DEPTH_LOG2_DEF     = 4;
  localparam int AFULL_MARGIN_DEF   = 2;

  typedef struct packed {
    logic                          last;
    logic [DATAPATH_WIDTH_DEF-1:0] data;
  } entry_t;
endpackage

// File: rtl/intpol2_d4_out_fifo_if.sv
// intpol2_d4_out_fifo_if
// Write-side strobe/flags and read-side valid/ready stream of the output FIFO.
//   slave  : FIFO view (takes pushes, drives flags and the output stream)
//   master : surrounding view (datapath writer + stream sink)
interface intpol2_d4_out_fifo_if #(
  parameter int DATAPATH_WIDTH = intpol2_d4_out_fifo_pkg::DATAPATH_WIDTH_DEF
);
  logic                      Write_Enable;
  logic [DATAPATH_WIDTH-1:0] data_i;
  logic                      last_i;
  logic                      Afull_o;
  logic                      full_o;
  logic                      overflow_o;
  logic                      m_valid;
  logic                      m_ready;
  logic [DATAPATH_WIDTH-1:0] m_data;
  logic                      m_last;

  modport slave (
    input  Write_Enable, data_i, last_i, m_ready,
    output Afull_o, full_o, overflow_o, m_valid, m_data, m_last
  );
  modport master (
    output Write_Enable, data_i, last_i, m_ready,
    input  Afull_o, full_o, overflow_o, m_valid, m_data, m_last
  );
endinterface

// File: rtl/intpol2_d4_out_fifo_mem.sv
// intpol2_d4_out_fifo_mem
// Simple dual-port register array: one synchronous write port, one
// asynchronous read port. Contents are never reset.
//   clk          : clock
//   we/waddr/wdata : write port
//   raddr/rdata  : combinational read port
module intpol2_d4_out_fifo_mem #(
  parameter int W  = 33,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [1<<AW];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/intpol2_d4_out_fifo.sv
// intpol2_d4_out_fifo
// Output buffer behind the intpol2_D4 datapath. Pushes on Write_Enable, feeds
// Afull_o back to the controlpath, drains through a first-word-fall-through
// valid/ready stream with an end-of-block flag.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : synchronous flush (keeps overflow_o)
//   bus        : write strobe/data/last, flags, m_* output stream
// Optional (macro INTPOL2_D4_OUT_FIFO_LEVEL_EN):
//   level_o     : registered occupancy
//   underflow_o : sticky, sink ready with no data while a block is open
module intpol2_d4_out_fifo
  import intpol2_d4_out_fifo_pkg::*;
#(
  parameter int DATAPATH_WIDTH = DATAPATH_WIDTH_DEF,
  parameter int DEPTH_LOG2     = DEPTH_LOG2_DEF,
  parameter int AFULL_MARGIN   = AFULL_MARGIN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  intpol2_d4_out_fifo_if.slave  bus
`ifdef INTPOL2_D4_OUT_FIFO_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  underflow_o
`endif
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_TH  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AFULL_TH = (DEPTH_LOG2+1)'(DEPTH - AFULL_MARGIN);

  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]     count, count_nxt;
  logic                    full_q, afull_q, ovf_q;
  logic                    out_vld, out_last;
  logic [DATAPATH_WIDTH-1:0] out_data;
  logic [DATAPATH_WIDTH:0] rd_entry;
  logic push, pop, mem_empty, out_free, bypass, mem_we, mem_re;

  // count includes the output register; memory holds count - out_vld entries.
  // out_vld == 0 always implies the memory is empty.
  assign push      = bus.Write_Enable && !full_q;
  assign pop       = out_vld && bus.m_ready;
  assign mem_empty = (wr_ptr == rd_ptr);
  assign out_free  = !out_vld || pop;
  // Straight into the output register when nothing is queued ahead, so a
  // push/pop every cycle streams without bubbles.
  assign bypass    = push && mem_empty && out_free;
  assign mem_we    = push && !bypass;
  assign mem_re    = out_free && !mem_empty;
  assign count_nxt = count + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};

  intpol2_d4_out_fifo_mem #(.W(DATAPATH_WIDTH+1), .AW(DEPTH_LOG2)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata ({bus.last_i, bus.data_i}),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
    end else begin
      if (bus.Write_Enable && full_q) ovf_q <= 1'b1;
      if (mem_we) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (mem_re) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      count   <= count_nxt;
      full_q  <= (count_nxt == FULL_TH);
      afull_q <= (count_nxt >= AFULL_TH);
      if (mem_re) begin
        out_vld              <= 1'b1;
        {out_last, out_data} <= rd_entry;
      end else if (bypass) begin
        out_vld  <= 1'b1;
        out_last <= bus.last_i;
        out_data <= bus.data_i;
      end else if (pop) begin
        out_vld  <= 1'b0;
      end
    end
  end

  assign bus.full_o     = full_q;
  assign bus.Afull_o    = afull_q;
  assign bus.overflow_o = ovf_q;
  assign bus.m_valid    = out_vld;
  assign bus.m_data     = out_data;
  assign bus.m_last     = out_last;

`ifdef INTPOL2_D4_OUT_FIFO_LEVEL_EN
  logic blk_open, unf_q;

  // A block is open from its first accepted push until its last entry pops;
  // a new push in the same cycle as that pop opens the next block.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_open <= 1'b0;
      unf_q    <= 1'b0;
    end else if (clear) begin
      blk_open <= 1'b0;
    end else begin
      if (bus.m_ready && !out_vld && blk_open) unf_q <= 1'b1;
      if (push)                 blk_open <= 1'b1;
      else if (pop && out_last) blk_open <= 1'b0;
    end
  end

  assign level_o     = count;
  assign underflow_o = unf_q;
`endif
endmodule
